// File: rtl/alarm_tone_gen.sv
// Alarm tone generator: per-zone square-wave beeps, BEEP_COUNT beeps per accepted alarm.
// Optional one-deep request queue compiled in with macro ALARM_TONE_PENDING_EN.
module alarm_tone_gen #(
  parameter int TONE_DIV_BASE = 4,
  parameter int BEEP_LEN      = 16,
  parameter int GAP_LEN       = 8,
  parameter int BEEP_COUNT    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       zone_valid,
  input  logic [1:0] zone_id,
  output logic       zone_ready,
  output logic       spk,
  output logic [2:0] zone_led,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam logic [7:0] DIV_W     = 8'(TONE_DIV_BASE);
  localparam logic [7:0] BEEP_LAST = 8'(BEEP_LEN - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_LEN - 1);
  localparam logic [3:0] COUNT_W   = 4'(BEEP_COUNT);

  function automatic logic [2:0] zone_onehot(input logic [1:0] z);
    logic [2:0] oh;
    case (z)
      2'd1:    oh = 3'b001;
      2'd2:    oh = 3'b010;
      2'd3:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  state_e     state_q, state_d;
  logic [1:0] zone_q, zone_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] phase_q, phase_d;
  logic [7:0] tone_q, tone_d;
  logic       spk_q, spk_d;
  logic [2:0] led_q, led_d;
  logic       pend_vld_q, pend_vld_d;
  logic [1:0] pend_zone_q, pend_zone_d;

  logic       req_s;
  logic       start_s;
  logic       end_s;
  logic [1:0] start_zone_s;
  logic [7:0] half_s;

`ifdef ALARM_TONE_PENDING_EN
  assign zone_ready = ena & ((state_q == ST_IDLE) | ~pend_vld_q);
`else
  assign zone_ready = ena & (state_q == ST_IDLE);
`endif

  assign req_s    = zone_valid & zone_ready & (zone_id != 2'd0);
  assign half_s   = DIV_W * {6'd0, zone_q};
  assign spk      = spk_q;
  assign zone_led = led_q;
  assign busy     = (state_q != ST_IDLE);

  // Next-state logic: sequencer, tone divider and pending-slot handling.
  always_comb begin
    state_d      = state_q;
    zone_d       = zone_q;
    idx_d        = idx_q;
    phase_d      = phase_q;
    tone_d       = tone_q;
    spk_d        = spk_q;
    led_d        = led_q;
    pend_vld_d   = pend_vld_q;
    pend_zone_d  = pend_zone_q;
    start_s      = 1'b0;
    end_s        = 1'b0;
    start_zone_s = 2'd0;

    if (ena) begin
      case (state_q)
        ST_IDLE: begin
          if (req_s) begin
            start_s      = 1'b1;
            start_zone_s = zone_id;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ON: begin
          if (phase_q == BEEP_LAST) begin
            state_d = ST_GAP;
            phase_d = 8'd0;
            tone_d  = 8'd0;
            spk_d   = 1'b0;
          end else if (tone_q == half_s - 8'd1) begin
            phase_d = phase_q + 8'd1;
            tone_d  = 8'd0;
            spk_d   = ~spk_q;
          end else begin
            phase_d = phase_q + 8'd1;
            tone_d  = tone_q + 8'd1;
          end
        end
        ST_GAP: begin
          if (phase_q != GAP_LAST) begin
            phase_d = phase_q + 8'd1;
          end else if ((idx_q + 4'd1) < COUNT_W) begin
            state_d = ST_ON;
            idx_d   = idx_q + 4'd1;
            phase_d = 8'd0;
            tone_d  = 8'd0;
            spk_d   = 1'b1;
          end else begin
            end_s = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      // Sequence end: chain straight into a queued zone, else fall back to IDLE.
      if (end_s) begin
`ifdef ALARM_TONE_PENDING_EN
        if (pend_vld_q) begin
          start_s      = 1'b1;
          start_zone_s = pend_zone_q;
          pend_vld_d   = 1'b0;
        end else if (req_s) begin
          start_s      = 1'b1;
          start_zone_s = zone_id;
        end else begin
          start_s = 1'b0;
        end
`endif
        state_d = ST_IDLE;
        zone_d  = 2'd0;
        idx_d   = 4'd0;
        phase_d = 8'd0;
        tone_d  = 8'd0;
        spk_d   = 1'b0;
        led_d   = 3'b000;
      end else begin
`ifdef ALARM_TONE_PENDING_EN
        if ((state_q != ST_IDLE) && req_s) begin
          pend_vld_d  = 1'b1;
          pend_zone_d = zone_id;
        end else begin
          pend_vld_d = pend_vld_q;
        end
`endif
      end

      if (start_s) begin
        state_d = ST_ON;
        zone_d  = start_zone_s;
        idx_d   = 4'd0;
        phase_d = 8'd0;
        tone_d  = 8'd0;
        spk_d   = 1'b1;
        led_d   = zone_onehot(start_zone_s);
      end else begin
        zone_d = zone_d;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      zone_q      <= 2'd0;
      idx_q       <= 4'd0;
      phase_q     <= 8'd0;
      tone_q      <= 8'd0;
      spk_q       <= 1'b0;
      led_q       <= 3'b000;
      pend_vld_q  <= 1'b0;
      pend_zone_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      zone_q      <= zone_d;
      idx_q       <= idx_d;
      phase_q     <= phase_d;
      tone_q      <= tone_d;
      spk_q       <= spk_d;
      led_q       <= led_d;
      pend_vld_q  <= pend_vld_d;
      pend_zone_q <= pend_zone_d;
    end
  end

endmodule
